pipeline_sequencer: RTL and testbench

Parametrised stage sequencer for the CPU pipeline: it generates the PC write enable, the pipeline-register write enables, and the RAM and register-file write strobes for an N-stage core. It runs in two modes:
- **Sequential:** one instruction occupies the pipeline at a time.
- **Pipelined:** overlapped execution, with per-stage valid tracking, load-use stall bubbles and branch flushes.

It sits at the top of the core, between the hazard/branch logic and every pipeline register.

---
 rtl/pipeline_sequencer_if.sv | 31 +++
 rtl/pipeline_sequencer.sv | 126 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the hazard/branch logic and the pipeline sequencer.
// The master drives the requests; the slave (the sequencer) drives the strobes and status.
interface pipeline_sequencer_if #(
  parameter int NUM_STAGES = 5
);
  logic                  mode;
  logic                  run;
  logic                  stall_req;
  logic                  flush_req;
  logic                  pc_wren;
  logic [NUM_STAGES-2:0] stage_wren;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  ram_wren;
  logic                  reg_wren;
  logic                  mode_q;
  logic                  busy;
  logic [31:0]           retired_count;
  logic [31:0]           stall_count;

  modport master (
    output mode, run, stall_req, flush_req,
    input  pc_wren, stage_wren, stage_valid, ram_wren, reg_wren,
           mode_q, busy, retired_count, stall_count
  );

  modport slave (
    input  mode, run, stall_req, flush_req,
    output pc_wren, stage_wren, stage_valid, ram_wren, reg_wren,
           mode_q, busy, retired_count, stall_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stage sequencer generating PC, pipeline-register, RAM and register-file write enables.
// Optional retirement/stall counters are built only when PIPELINE_SEQUENCER_PERF_EN is defined.
module pipeline_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int RAM_STAGE   = 3,
  parameter int STALL_STAGE = 2,
  parameter int FLUSH_DEPTH = 3
) (
  input logic                clk,
  input logic                reset_n,
  pipeline_sequencer_if.slave bus
);
  localparam int TOK_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(NUM_STAGES - 1);

  logic [NUM_STAGES-1:1] v;
  logic [TOK_W-1:0]      tok;
  logic                  act;
  logic                  mode_q;

  logic [NUM_STAGES-1:0] chain;
  logic                  stall_app;
  logic                  pc_wren;
  logic [NUM_STAGES-2:0] stage_wren;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  ram_wren;
  logic                  reg_wren;
  logic                  busy;

  // A flush overrides a simultaneous stall; neither applies in sequential mode.
  assign stall_app = mode_q & bus.stall_req & ~bus.flush_req;
  assign chain     = {v, bus.run};
  assign busy      = |stage_valid;

  always_comb begin
    pc_wren     = 1'b0;
    stage_wren  = '0;
    stage_valid = '0;
    ram_wren    = 1'b0;
    reg_wren    = 1'b0;
    if (mode_q) begin
      stage_valid = chain;
      pc_wren     = bus.flush_req | (bus.run & ~bus.stall_req);
      stage_wren  = '1;
      if (stall_app) begin
        for (int i = 0; i < NUM_STAGES - 1; i++)
          if (i < STALL_STAGE - 1) stage_wren[i] = 1'b0;
      end
      ram_wren = v[RAM_STAGE];
      reg_wren = v[NUM_STAGES-1];
    end else if (act) begin
      for (int i = 0; i < NUM_STAGES; i++)
        if (tok == TOK_W'(i)) stage_valid[i] = 1'b1;
      for (int i = 0; i < NUM_STAGES - 1; i++)
        if (tok == TOK_W'(i)) stage_wren[i] = 1'b1;
      ram_wren = (tok == TOK_W'(RAM_STAGE));
      reg_wren = (tok == TOK_LAST);
      pc_wren  = (tok == TOK_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v      <= '0;
      tok    <= '0;
      act    <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      // Mode only changes once both the pipeline and the sequential token are idle.
      if (!busy && !act) mode_q <= bus.mode;
      if (!mode_q) begin
        if (act) begin
          if (tok == TOK_LAST) begin
            tok <= '0;
            act <= bus.run;
          end else begin
            tok <= tok + 1'b1;
          end
        end else if (bus.run && !bus.mode) begin
          act <= 1'b1;
          tok <= '0;
        end
      end else begin
        for (int i = 1; i < NUM_STAGES; i++) begin
          if (bus.flush_req && i < FLUSH_DEPTH)
            v[i] <= 1'b0;
          else if (stall_app && i < STALL_STAGE)
            v[i] <= v[i];
          else if (stall_app && i == STALL_STAGE)
            v[i] <= 1'b0;
          else
            v[i] <= chain[i-1];
        end
      end
    end
  end

`ifdef PIPELINE_SEQUENCER_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (reg_wren)  retired_cnt <= retired_cnt + 32'd1;
      if (stall_app) stall_cnt   <= stall_cnt + 32'd1;
    end
  end

  assign bus.retired_count = retired_cnt;
  assign bus.stall_count   = stall_cnt;
`else
  assign bus.retired_count = '0;
  assign bus.stall_count   = '0;
`endif

  assign bus.pc_wren     = pc_wren;
  assign bus.stage_wren  = stage_wren;
  assign bus.stage_valid = stage_valid;
  assign bus.ram_wren    = ram_wren;
  assign bus.reg_wren    = reg_wren;
  assign bus.mode_q      = mode_q;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with default parameters (5 stages).
module tb_pipeline_sequencer;
`ifdef PIPELINE_SEQUENCER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   passed;
  int   total;

  pipeline_sequencer_if #(.NUM_STAGES(5)) bus ();

  pipeline_sequencer #(
    .NUM_STAGES (5),
    .RAM_STAGE  (3),
    .STALL_STAGE(2),
    .FLUSH_DEPTH(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n       = 1'b0;
    bus.mode      = 1'b1;
    bus.run       = 1'b1;
    bus.stall_req = 1'b1;
    bus.flush_req = 1'b1;
    #3;
    repeat (2) begin
      total++;
      if (bus.stage_valid !== 5'b0) $display("FAIL reset_stage_valid got %b want 00000", bus.stage_valid);
      else passed++;
      total++;
      if (bus.stage_wren !== 4'b0) $display("FAIL reset_stage_wren got %b want 0000", bus.stage_wren);
      else passed++;
      total++;
      if ({bus.pc_wren, bus.ram_wren, bus.reg_wren, bus.mode_q, bus.busy} !== 5'b0)
        $display("FAIL reset_strobes got %b want 00000",
                 {bus.pc_wren, bus.ram_wren, bus.reg_wren, bus.mode_q, bus.busy});
      else passed++;
      total++;
      if ({bus.retired_count, bus.stall_count} !== 64'd0)
        $display("FAIL reset_counters got %0d/%0d want 0/0", bus.retired_count, bus.stall_count);
      else passed++;
      wait_edge;
    end
    bus.mode      = 1'b0;
    bus.run       = 1'b0;
    bus.stall_req = 1'b0;
    bus.flush_req = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  task automatic test_sequential;
    int ph;
    wait_edge;
    bus.run = 1'b1;
    #1;
    total++;
    if (bus.stage_valid !== 5'b0) $display("FAIL seq_start_cycle got %b want 00000", bus.stage_valid);
    else passed++;
    wait_edge;
    for (int c = 0; c < 10; c++) begin
      ph = c % 5;
      if (c == 9) bus.run = 1'b0;
      #1;
      total++;
      if (bus.stage_valid !== 5'(1 << ph))
        $display("FAIL seq_valid c%0d got %b want %b", c, bus.stage_valid, 5'(1 << ph));
      else passed++;
      total++;
      if (bus.stage_wren !== ((ph < 4) ? 4'(1 << ph) : 4'b0))
        $display("FAIL seq_wren c%0d got %b want %b", c, bus.stage_wren, (ph < 4) ? 4'(1 << ph) : 4'b0);
      else passed++;
      total++;
      if ({bus.pc_wren, bus.reg_wren, bus.ram_wren} !== {ph == 4, ph == 4, ph == 3})
        $display("FAIL seq_strobes c%0d got %b want %b", c,
                 {bus.pc_wren, bus.reg_wren, bus.ram_wren}, {ph == 4, ph == 4, ph == 3});
      else passed++;
      wait_edge;
    end
    total++;
    if (bus.stage_valid !== 5'b0 || bus.busy !== 1'b0)
      $display("FAIL seq_idle got %b busy %b want 00000 busy 0", bus.stage_valid, bus.busy);
    else passed++;
    total++;
    if (bus.retired_count !== (PERF ? 32'd2 : 32'd0))
      $display("FAIL seq_retired got %0d want %0d", bus.retired_count, PERF ? 2 : 0);
    else passed++;
  endtask

  task automatic test_pipelined_fill;
    logic [31:0] base;
    int          n;
    logic [4:0]  exp_v;
    bus.mode = 1'b1;
    n = 0;
    while (bus.mode_q !== 1'b1 && n < 5) begin
      wait_edge;
      n++;
    end
    total++;
    if (bus.mode_q !== 1'b1) $display("FAIL pipe_mode_q got %b want 1", bus.mode_q);
    else passed++;
    base    = bus.retired_count;
    bus.run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      exp_v = 5'((1 << (((c < 4) ? c : 4) + 1)) - 1);
      total++;
      if (bus.stage_valid !== exp_v)
        $display("FAIL pipe_fill_valid c%0d got %b want %b", c, bus.stage_valid, exp_v);
      else passed++;
      total++;
      if ({bus.reg_wren, bus.pc_wren, bus.stage_wren} !== {c >= 4, 1'b1, 4'b1111})
        $display("FAIL pipe_fill_strobes c%0d got %b want %b", c,
                 {bus.reg_wren, bus.pc_wren, bus.stage_wren}, {c >= 4, 1'b1, 4'b1111});
      else passed++;
      total++;
      if (bus.retired_count !== (PERF ? base + 32'((c > 4) ? c - 4 : 0) : 32'd0))
        $display("FAIL pipe_fill_retired c%0d got %0d want %0d", c, bus.retired_count,
                 PERF ? base + 32'((c > 4) ? c - 4 : 0) : 32'd0);
      else passed++;
      wait_edge;
    end
  endtask

  task automatic test_stall;
    logic [31:0] base;
    base          = bus.stall_count;
    bus.stall_req = 1'b1;
    #1;
    total++;
    if ({bus.pc_wren, bus.stage_wren, bus.stage_valid} !== {1'b0, 4'b1110, 5'b11111})
      $display("FAIL stall_cycle got pc %b wren %b valid %b want pc 0 wren 1110 valid 11111",
               bus.pc_wren, bus.stage_wren, bus.stage_valid);
    else passed++;
    wait_edge;
    bus.stall_req = 1'b0;
    #1;
    total++;
    if (bus.stage_valid !== 5'b11011) $display("FAIL stall_bubble got %b want 11011", bus.stage_valid);
    else passed++;
    total++;
    if (bus.stall_count !== (PERF ? base + 32'd1 : 32'd0))
      $display("FAIL stall_count got %0d want %0d", bus.stall_count, PERF ? base + 32'd1 : 32'd0);
    else passed++;
    wait_edge;
    wait_edge;
    total++;
    if (bus.stage_valid !== 5'b01111 || bus.reg_wren !== 1'b0)
      $display("FAIL stall_wb_bubble got %b reg %b want 01111 reg 0", bus.stage_valid, bus.reg_wren);
    else passed++;
    wait_edge;
    total++;
    if (bus.stage_valid !== 5'b11111) $display("FAIL stall_refill got %b want 11111", bus.stage_valid);
    else passed++;
  endtask

  task automatic test_flush;
    logic [31:0] base;
    base          = bus.stall_count;
    bus.flush_req = 1'b1;
    bus.stall_req = 1'b1;
    #1;
    total++;
    if ({bus.pc_wren, bus.stage_wren} !== {1'b1, 4'b1111})
      $display("FAIL flush_cycle got pc %b wren %b want pc 1 wren 1111", bus.pc_wren, bus.stage_wren);
    else passed++;
    wait_edge;
    bus.flush_req = 1'b0;
    bus.stall_req = 1'b0;
    #1;
    total++;
    if (bus.stage_valid !== 5'b11001) $display("FAIL flush_squash got %b want 11001", bus.stage_valid);
    else passed++;
    total++;
    if (bus.stall_count !== base) $display("FAIL flush_stall_count got %0d want %0d", bus.stall_count, base);
    else passed++;
    repeat (3) wait_edge;
  endtask

  task automatic test_mode_change;
    int  n;
    bit  seen;
    bus.mode = 1'b0;
    repeat (3) wait_edge;
    total++;
    if (bus.mode_q !== 1'b1) $display("FAIL mode_busy_hold got %b want 1", bus.mode_q);
    else passed++;
    bus.run = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 10) begin
      #1;
      if (bus.stage_valid === 5'b0) seen = 1'b1;
      else begin
        wait_edge;
        n++;
      end
    end
    total++;
    if (!seen || bus.mode_q !== 1'b1)
      $display("FAIL mode_drain got seen %b mode_q %b want seen 1 mode_q 1", seen, bus.mode_q);
    else passed++;
    wait_edge;
    total++;
    if (bus.mode_q !== 1'b0) $display("FAIL mode_switch got %b want 0", bus.mode_q);
    else passed++;
  endtask

  task automatic test_async_reset;
    bus.run = 1'b1;
    repeat (3) wait_edge;
    total++;
    if (bus.stage_valid !== 5'b00100) $display("FAIL arst_pre got %b want 00100", bus.stage_valid);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.stage_valid, bus.busy, bus.mode_q, bus.retired_count} !== 39'd0)
      $display("FAIL arst_clear got valid %b busy %b retired %0d want all 0",
               bus.stage_valid, bus.busy, bus.retired_count);
    else passed++;
    bus.run = 1'b0;
    wait_edge;
    #2 reset_n = 1'b1;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    reset_n       = 1'b0;
    bus.mode      = 1'b0;
    bus.run       = 1'b0;
    bus.stall_req = 1'b0;
    bus.flush_req = 1'b0;
    test_reset;
    test_sequential;
    test_pipelined_fill;
    test_stall;
    test_flush;
    test_mode_change;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
